// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the serial subtractor: operands in, result and flags out.
// The requester owns start/a/b/borrow_in; the subtractor owns ready/done and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, a, b, borrow_in,
    input  ready, done, diff, borrow_out, overflow, zero, negative
  );

  modport slave (
    input  start, a, b, borrow_in,
    output ready, done, diff, borrow_out, overflow, zero, negative
  );
endinterface

// File: rtl/serial_subtractor.sv
// LSB-first multi-cycle a - b - borrow_in; done pulses WIDTH/BITS_PER_CYCLE cycles after start.
// start is only accepted while ready=1 (IDLE); it is dropped, never queued, during RUN/DONE.
module serial_subtractor #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  io
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]          a_q, a_d;
  logic [WIDTH-1:0]          b_q, b_d;
  logic [WIDTH-1:0]          sh_q, sh_d;
  logic                      br_q, br_d;
  logic                      amsb_q, amsb_d;
  logic                      bmsb_q, bmsb_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic [WIDTH-1:0]          diff_q, diff_d;
  logic                      borrow_out_q, borrow_out_d;
  logic                      overflow_q, overflow_d;
  logic                      zero_q, zero_d;
  logic                      negative_q, negative_d;

  logic [BITS_PER_CYCLE-1:0] slice_c;
  logic                      br_c;
  logic [WIDTH-1:0]          sh_next_c;

  // Full-subtractor slice: borrow ripples through the slice, then into br_q for the next cycle.
  always_comb begin
    slice_c = '0;
    br_c    = br_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_c[i] = a_q[i] ^ b_q[i] ^ br_c;
      br_c       = (~a_q[i] & b_q[i]) | (br_c & ~(a_q[i] ^ b_q[i]));
    end
    sh_next_c = (sh_q >> BITS_PER_CYCLE) | (WIDTH'(slice_c) << (WIDTH - BITS_PER_CYCLE));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sh_d         = sh_q;
    br_d         = br_q;
    amsb_d       = amsb_q;
    bmsb_d       = bmsb_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    negative_d   = negative_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (io.start) begin
          a_d     = io.a;
          b_d     = io.b;
          br_d    = io.borrow_in;
          amsb_d  = io.a[WIDTH-1];
          bmsb_d  = io.b[WIDTH-1];
          sh_d    = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        sh_d  = sh_next_c;
        br_d  = br_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Results are published only here, so they never expose a partial difference.
          diff_d       = sh_next_c;
          borrow_out_d = br_c;
          zero_d       = ~|sh_next_c;
          negative_d   = sh_next_c[WIDTH-1];
          overflow_d   = (amsb_q ^ bmsb_q) & (sh_next_c[WIDTH-1] ^ amsb_q);
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      br_q         <= 1'b0;
      amsb_q       <= 1'b0;
      bmsb_q       <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sh_q         <= sh_d;
      br_q         <= br_d;
      amsb_q       <= amsb_d;
      bmsb_q       <= bmsb_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      zero_q       <= zero_d;
      negative_q   <= negative_d;
    end
  end

  assign io.ready      = ready_q;
  assign io.done       = done_q;
  assign io.diff       = diff_q;
  assign io.borrow_out = borrow_out_q;
  assign io.overflow   = overflow_q;
  assign io.zero       = zero_q;
  assign io.negative   = negative_q;
endmodule
